// File: rtl/sum_rx_ctrl.sv
// sum_rx_ctrl: receive side of the inter-core partial-sum exchange.
// Completes a four-phase req/ack handshake with the peer and captures each
// offered sum into a small circular FIFO that the local core drains.
// Optional macro SUM_RX_SYNC_EN: passes rx_req through a two-flop
// synchronizer before the FSM, which adds two cycles of request latency.
module sum_rx_ctrl #(
    parameter int bw_psum = 20,
    parameter int depth   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rx_req,
    output logic                     rx_ack,
    input  logic [bw_psum+3:0]       rx_sum_in,
    input  logic                     rd_en,
    output logic                     sum_valid,
    output logic [bw_psum+3:0]       sum_rd,
    output logic                     fifo_full,
    output logic [$clog2(depth):0]   fifo_cnt
);
    localparam int AW = $clog2(depth);
    localparam int DW = bw_psum + 4;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(depth);

    typedef enum logic [1:0] {ARM, IDLE, ACK} state_t;

    state_t          state_q, state_d;
    logic            rx_ack_q, rx_ack_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     cnt_q, cnt_d;
    logic [DW-1:0]   mem_q [depth];
    logic            req_s;
    logic            push, pop;

`ifdef SUM_RX_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchronizer on the peer request; data is held stable by the protocol.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= 2'b00;
        else       sync_q <= {sync_q[0], rx_req};
    end

    assign req_s = sync_q[1];
`else
    assign req_s = rx_req;
`endif

    // Handshake FSM: ARM waits for a low request so a handshake cut by reset is not re-captured.
    always_comb begin
        state_d  = state_q;
        rx_ack_d = rx_ack_q;
        push     = 1'b0;
        case (state_q)
            ARM:  if (!req_s) state_d = IDLE;
            IDLE: if (req_s && !fifo_full) begin
                      push     = 1'b1;
                      rx_ack_d = 1'b1;
                      state_d  = ACK;
                  end
            ACK:  if (!req_s) begin
                      rx_ack_d = 1'b0;
                      state_d  = IDLE;
                  end
            default: state_d = ARM;
        endcase
    end

    assign pop = rd_en && (cnt_q != '0);

    // Occupancy: simultaneous push and pop leave the count unchanged.
    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state: FSM, ack, pointers and count all clear on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ARM;
            rx_ack_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rx_ack_q <= rx_ack_d;
            cnt_q    <= cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    // Storage array needs no reset; entries are only read when counted valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= rx_sum_in;
    end

    assign rx_ack    = rx_ack_q;
    assign sum_valid = (cnt_q != '0);
    assign fifo_full = (cnt_q == FULL_CNT);
    assign fifo_cnt  = cnt_q;
    assign sum_rd    = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_sum_rx_ctrl.sv
// Self-checking bench for sum_rx_ctrl: a peer model drives the handshake, an
// expected-value queue stands in for the FIFO, and each scenario checks inline.
module tb_sum_rx_ctrl;
    localparam int BW  = 20;
    localparam int DW  = BW + 4;
    localparam int DEP = 4;
`ifdef SUM_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_req;
    logic          rx_ack;
    logic [DW-1:0] rx_sum_in;
    logic          rd_en;
    logic          sum_valid;
    logic [DW-1:0] sum_rd;
    logic          fifo_full;
    logic [2:0]    fifo_cnt;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];

    sum_rx_ctrl #(.bw_psum(BW), .depth(DEP)) dut (
        .clk(clk), .reset(reset), .rx_req(rx_req), .rx_ack(rx_ack),
        .rx_sum_in(rx_sum_in), .rd_en(rd_en), .sum_valid(sum_valid),
        .sum_rd(sum_rd), .fifo_full(fifo_full), .fifo_cnt(fifo_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Peer side of one full four-phase transfer; the model gains the value on ack.
    task automatic xfer(input logic [DW-1:0] v);
        int n;
        rx_sum_in = v;
        rx_req    = 1'b1;
        n = 0;
        while (rx_ack !== 1'b1 && n < 30) begin step(); n++; end
        total++;
        if (rx_ack !== 1'b1) begin
            bad++; $display("FAIL xfer_ack_rise value=%h ack=%b want 1", v, rx_ack);
        end else exp_q.push_back(v);
        rx_req = 1'b0;
        n = 0;
        while (rx_ack !== 1'b0 && n < 30) begin step(); n++; end
        total++;
        if (rx_ack !== 1'b0) begin
            bad++; $display("FAIL xfer_ack_fall ack=%b want 0", rx_ack);
        end
    endtask

    // Consumer pop: the head must match the oldest value the peer delivered.
    task automatic pop_chk();
        logic [DW-1:0] e;
        e = (exp_q.size() != 0) ? exp_q[0] : 'x;
        total++;
        if (sum_valid !== 1'b1 || exp_q.size() == 0 || sum_rd !== e) begin
            bad++; $display("FAIL pop_head got=%h valid=%b want=%h", sum_rd, sum_valid, e);
        end
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    task automatic test_reset();
        reset = 1'b1; rx_req = 1'b0; rx_sum_in = '0; rd_en = 1'b0;
        step(); step();
        total++;
        if (rx_ack !== 1'b0 || sum_valid !== 1'b0 || fifo_full !== 1'b0 || fifo_cnt !== 3'd0) begin
            bad++; $display("FAIL reset_state ack=%b valid=%b full=%b cnt=%0d want 0 0 0 0",
                            rx_ack, sum_valid, fifo_full, fifo_cnt);
        end
        reset = 1'b0;
        step(); step(); step();
    endtask

    task automatic test_single();
        rx_sum_in = 24'h0ABCDE;
        rx_req    = 1'b1;
        for (int e = 1; e <= LAT + 1; e++) begin
            step();
            total++;
            if (rx_ack !== (e == LAT + 1)) begin
                bad++; $display("FAIL single_rise edge=%0d ack=%b want %b", e, rx_ack, e == LAT + 1);
            end
        end
        exp_q.push_back(24'h0ABCDE);
        total++;
        if (sum_valid !== 1'b1 || sum_rd !== 24'h0ABCDE || fifo_cnt !== 3'd1) begin
            bad++; $display("FAIL single_data valid=%b rd=%h cnt=%0d want 1 0abcde 1",
                            sum_valid, sum_rd, fifo_cnt);
        end
        rx_req = 1'b0;
        for (int e = 1; e <= LAT + 1; e++) begin
            step();
            total++;
            if (rx_ack !== (e != LAT + 1)) begin
                bad++; $display("FAIL single_fall edge=%0d ack=%b want %b", e, rx_ack, e != LAT + 1);
            end
        end
        pop_chk();
        total++;
        if (fifo_cnt !== 3'd0 || sum_valid !== 1'b0) begin
            bad++; $display("FAIL single_drain cnt=%0d valid=%b want 0 0", fifo_cnt, sum_valid);
        end
    endtask

    task automatic test_fill();
        int hi;
        for (int i = 1; i <= 4; i++) xfer(DW'(i));
        total++;
        if (fifo_full !== 1'b1 || fifo_cnt !== 3'd4) begin
            bad++; $display("FAIL fill_full full=%b cnt=%0d want 1 4", fifo_full, fifo_cnt);
        end
        rx_sum_in = 24'd5;
        rx_req    = 1'b1;
        hi = 0;
        for (int i = 0; i < 6 + LAT; i++) begin step(); if (rx_ack !== 1'b0) hi++; end
        total++;
        if (hi != 0 || fifo_cnt !== 3'd4) begin
            bad++; $display("FAIL backpressure ack_high_cycles=%0d cnt=%0d want 0 4", hi, fifo_cnt);
        end
        pop_chk();
        total++;
        if (sum_rd !== 24'd2 || rx_ack !== 1'b0 || fifo_cnt !== 3'd3) begin
            bad++; $display("FAIL pop_while_full rd=%h ack=%b cnt=%0d want 2 0 3", sum_rd, rx_ack, fifo_cnt);
        end
        step();
        total++;
        if (rx_ack !== 1'b1 || fifo_cnt !== 3'd4) begin
            bad++; $display("FAIL deferred_push ack=%b cnt=%0d want 1 4", rx_ack, fifo_cnt);
        end
        exp_q.push_back(24'd5);
        rx_req = 1'b0;
        for (int i = 0; i < LAT + 1; i++) step();
        while (exp_q.size() != 0) pop_chk();
    endtask

    task automatic test_wrap();
        int nrx = 0, maxcnt = 0, cyc = 0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    xfer(DW'(8'h10 + i));
                    repeat ($urandom_range(0, 2)) step();
                end
            end
            begin
                while (nrx < 10 && cyc < 400) begin
                    if (int'(fifo_cnt) > maxcnt) maxcnt = int'(fifo_cnt);
                    if (sum_valid === 1'b1) begin
                        total++;
                        if (sum_rd !== DW'(8'h10 + nrx)) begin
                            bad++; $display("FAIL wrap_order idx=%0d got=%h want=%h", nrx, sum_rd, 8'h10 + nrx);
                        end
                        nrx++;
                        rd_en = 1'b1;
                    end else rd_en = 1'b0;
                    step();
                    cyc++;
                end
                rd_en = 1'b0;
            end
        join
        exp_q.delete();
        total++;
        if (nrx != 10 || maxcnt > 2 || fifo_cnt !== 3'd0) begin
            bad++; $display("FAIL wrap_count received=%0d maxcnt=%0d cnt=%0d want 10 <=2 0", nrx, maxcnt, fifo_cnt);
        end
    endtask

    task automatic test_empty_pop();
        rd_en = 1'b1;
        step(); step();
        rd_en = 1'b0;
        total++;
        if (fifo_cnt !== 3'd0 || sum_valid !== 1'b0) begin
            bad++; $display("FAIL empty_pop cnt=%0d valid=%b want 0 0", fifo_cnt, sum_valid);
        end
        xfer(24'hFFFFFF);
        pop_chk();
        total++;
        if (fifo_cnt !== 3'd0) begin
            bad++; $display("FAIL empty_pop_after cnt=%0d want 0", fifo_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0, hi = 0;
        rx_sum_in = 24'h33;
        rx_req    = 1'b1;
        while (rx_ack !== 1'b1 && n < 30) begin step(); n++; end
        #2 reset = 1'b1;
        #1;
        total++;
        if (rx_ack !== 1'b0 || fifo_cnt !== 3'd0 || sum_valid !== 1'b0) begin
            bad++; $display("FAIL reset_mid ack=%b cnt=%0d valid=%b want 0 0 0", rx_ack, fifo_cnt, sum_valid);
        end
        exp_q.delete();
        step();
        reset = 1'b0;
        for (int i = 0; i < 6 + LAT; i++) begin step(); if (rx_ack !== 1'b0) hi++; end
        total++;
        if (hi != 0 || fifo_cnt !== 3'd0) begin
            bad++; $display("FAIL stale_req ack_high_cycles=%0d cnt=%0d want 0 0", hi, fifo_cnt);
        end
        rx_req = 1'b0;
        for (int i = 0; i < LAT + 2; i++) step();
        xfer(24'd7);
        total++;
        if (fifo_cnt !== 3'd1 || sum_rd !== 24'd7) begin
            bad++; $display("FAIL rearm_capture cnt=%0d rd=%h want 1 7", fifo_cnt, sum_rd);
        end
        pop_chk();
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            if (exp_q.size() != 0 && ($urandom_range(0, 2) == 0 || exp_q.size() == DEP))
                pop_chk();
            else
                xfer(DW'($urandom));
            total++;
            if (fifo_cnt !== 3'(exp_q.size()) || fifo_full !== (exp_q.size() == DEP)) begin
                bad++; $display("FAIL random_occupancy iter=%0d cnt=%0d full=%b want %0d",
                                i, fifo_cnt, fifo_full, exp_q.size());
            end
        end
        while (exp_q.size() != 0) pop_chk();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_wrap();
        test_empty_pop();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
